vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 800, meaning visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 40, meaning horizontal front porch in clocks.
REQ-003 The block SHALL have parameter H_SYNC, default 128, meaning horizontal sync pulse width in clocks.
REQ-004 The block SHALL have parameter H_BP, default 88, meaning horizontal back porch in clocks.
REQ-005 The block SHALL have parameters V_ACTIVE, V_FP, V_SYNC and V_BP, defaults 600, 1, 4 and 23, meaning vertical equivalents in lines.
REQ-006 The block SHALL have parameters H_POL and V_POL, default 1 each, meaning 1 = sync pulse high, 0 = sync pulse low.
REQ-007 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clock  in  1  pixel clock.
- reset  in  1  synchronous, active-high.
- scale  in  2  pixel replication: 0 = 1x, 1 = 2x, 2 = 4x, 3 = 4x.
- o_hsync  out  1  horizontal sync, polarity H_POL.
- o_vsync  out  1  vertical sync, polarity V_POL.
- o_blank  out  1  high on visible pixels (DAC BLANK_N convention).
- o_sync  out  1  constant 1.
- o_clock  out  1  equals clock.
- o_x  out  11  logical x.
- o_y  out  11  logical y.
- o_active  out  1  equals o_blank.
- o_line_start  out  1  one-cycle pulse on the first visible pixel of each visible line.
- o_frame_start  out  1  one-cycle pulse on pixel (0,0).
- o_vblank  out  1  high on every line >= V_ACTIVE.
REQ-008 Reset SHALL be reset, synchronous, active-high; the clock SHALL be clock.

Function
REQ-009 Horizontal counter h SHALL count 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, then wrap to 0.
REQ-010 Vertical counter v SHALL increment when h wraps and wrap to 0 after V_TOTAL-1, where V_TOTAL is the sum of the four V parameters.
REQ-011 Segment order SHALL be active, front porch, sync, back porch on both axes.
REQ-012 Horizontal sync SHALL be asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
REQ-013 Vertical sync SHALL be asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for whole lines.
REQ-014 Visible SHALL mean h < H_ACTIVE and v < V_ACTIVE.
REQ-015 All outputs except o_sync and o_clock SHALL be registered, with exactly 1 cycle latency from counter state, and all mutually aligned.
REQ-016 When visible, o_x SHALL be h >> scale_q and o_y SHALL be v >> scale_q; when not visible, both SHALL be 0.
REQ-017 scale SHALL be sampled into scale_q only in the cycle h==H_TOTAL-1 and v==V_TOTAL-1, so it takes effect at the next pixel (0,0) and never mid-frame.
REQ-018 A scale change at any other time SHALL be ignored until the next frame boundary.
REQ-019 o_line_start SHALL pulse when h==0 and v<V_ACTIVE.
REQ-020 o_frame_start SHALL pulse when h==0 and v==0, coincident with o_line_start.
REQ-021 Counter widths SHALL be 11 bits; the elaboration SHALL check H_TOTAL <= 2048 and V_TOTAL <= 2048, and every parameter >= 1.

Reset
REQ-022 While reset is high: h=0, v=0, scale_q=0.
REQ-023 While reset is high: o_hsync=!H_POL, o_vsync=!V_POL, o_blank=0, o_active=0, o_x=0, o_y=0, o_line_start=0, o_frame_start=0, o_vblank=0.
REQ-024 On the first clock edge after reset deasserts, outputs SHALL reflect h=0, v=0: o_frame_start=1, o_blank=1.
REQ-025 Reset mid-frame SHALL restart timing at (0,0) with no partial sync pulse extended.

Structure
REQ-026 Package vga_timing_pkg SHALL hold the timing constant sets SVGA_800x600_60 (defaults above) and VGA_640x480_60 (640/16/96/48, 480/10/2/33, polarity 0/0), plus the scale encoding.
REQ-027 One sub-module, vga_axis_counter, SHALL be instantiated twice (horizontal and vertical) with parameters ACTIVE, FP, SYNC, BP, POL.
REQ-028 Each vga_axis_counter SHALL take a tick enable and produce count, wrap, in_active and in_sync.

Verification
REQ-029 Defaults, release reset: o_frame_start period = 663168 cycles; o_hsync high for 128 cycles starting 840 cycles after each o_line_start.
REQ-030 Defaults: o_vsync high for exactly 4x1056 cycles, beginning 601 lines after o_frame_start; o_vblank high 28 lines per frame.
REQ-031 scale=1 held: o_x steps 0,0,1,1,...,399,399 per line, and o_y maxes at 299; change scale to 2 mid-frame -> current frame unchanged, next frame o_x max 199.
REQ-032 Small params (H 4/1/2/1, V 3/1/1/1, H_POL=0): o_hsync low exactly at h=5,6; frame = 48 cycles; o_blank count = 12 per frame.
REQ-033 Assert reset at h=900, v=300, for 3 cycles -> next output cycle o_frame_start=1, o_x=0, o_y=0, o_hsync=!H_POL.
REQ-034 VGA_640x480_60 set: o_frame_start period = 800x525 = 420000 cycles; syncs active-low.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing constants, scale encoding and helpers
// for the timing generator and its axis counters.
package vga_timing_pkg;

   localparam int CNT_W     = 11;
   localparam int MAX_TOTAL = 2048;

   typedef enum logic [1:0] {
      SCALE_1X     = 2'd0,
      SCALE_2X     = 2'd1,
      SCALE_4X     = 2'd2,
      SCALE_4X_ALT = 2'd3
   } scale_e;

   typedef struct packed {
      logic [CNT_W-1:0] h_active;
      logic [CNT_W-1:0] h_fp;
      logic [CNT_W-1:0] h_sync;
      logic [CNT_W-1:0] h_bp;
      logic [CNT_W-1:0] v_active;
      logic [CNT_W-1:0] v_fp;
      logic [CNT_W-1:0] v_sync;
      logic [CNT_W-1:0] v_bp;
      logic             h_pol;
      logic             v_pol;
   } vga_timing_t;

   localparam vga_timing_t SVGA_800x600_60 = '{
      h_active: 11'd800, h_fp: 11'd40, h_sync: 11'd128, h_bp: 11'd88,
      v_active: 11'd600, v_fp: 11'd1,  v_sync: 11'd4,   v_bp: 11'd23,
      h_pol:    1'b1,    v_pol: 1'b1
   };

   localparam vga_timing_t VGA_640x480_60 = '{
      h_active: 11'd640, h_fp: 11'd16, h_sync: 11'd96, h_bp: 11'd48,
      v_active: 11'd480, v_fp: 11'd10, v_sync: 11'd2,  v_bp: 11'd33,
      h_pol:    1'b0,    v_pol: 1'b0
   };

   // Both 4x encodings collapse to a shift of two.
   function automatic logic [1:0] scale_shift(input logic [1:0] s);
      logic [1:0] sh;
      unique case (s)
         SCALE_1X: sh = 2'd0;
         SCALE_2X: sh = 2'd1;
         default:  sh = 2'd2;
      endcase
      return sh;
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Axis counter status bundle and the video output bundle
// seen by a consumer of the timing generator.
interface vga_axis_if;
   logic [10:0] count;
   logic        wrap;
   logic        in_active;
   logic        in_sync;

   modport master (output count, wrap, in_active, in_sync);
   modport slave  (input  count, wrap, in_active, in_sync);
endinterface

interface vga_timing_gen_if;
   logic        hsync;
   logic        vsync;
   logic        blank;
   logic        sync;
   logic        pclk;
   logic        active;
   logic        line_start;
   logic        frame_start;
   logic        vblank;
   logic [10:0] x;
   logic [10:0] y;

   modport master (
      output hsync, vsync, blank, sync, pclk, active,
             line_start, frame_start, vblank, x, y
   );
   modport slave (
      input  hsync, vsync, blank, sync, pclk, active,
             line_start, frame_start, vblank, x, y
   );
endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// One timing axis: counts active, front porch, sync, back porch
// and flags the active and sync segments of the current count.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int ACTIVE = 800,
   parameter int FP     = 40,
   parameter int SYNC   = 128,
   parameter int BP     = 88,
   parameter int POL    = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        i_tick,
   vga_axis_if.master  o_axis
);

   localparam int TOTAL   = ACTIVE + FP + SYNC + BP;
   localparam int SYNC_LO = ACTIVE + FP;
   localparam int SYNC_HI = SYNC_LO + SYNC;

   localparam logic [CNT_W-1:0] L_LAST = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] L_ACT  = CNT_W'(ACTIVE);
   localparam logic [CNT_W-1:0] L_SLO  = CNT_W'(SYNC_LO);
   localparam logic [CNT_W-1:0] L_SHI  = CNT_W'(SYNC_HI);

   if (TOTAL > MAX_TOTAL || ACTIVE < 1 || FP < 1 || SYNC < 1 ||
       BP < 1 || POL < 0 || POL > 1) begin : g_bad_cfg
      $error("vga_axis_counter: invalid timing parameters");
   end

   logic [CNT_W-1:0] r_count;
   logic             w_last;

   assign w_last = (r_count == L_LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_tick) begin
         r_count <= w_last ? '0 : r_count + 1'b1;
      end
   end

   assign o_axis.count     = r_count;
   assign o_axis.wrap      = i_tick & w_last;
   assign o_axis.in_active = (r_count < L_ACT);
   assign o_axis.in_sync   = (r_count >= L_SLO) && (r_count < L_SHI);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA/SVGA raster timing with pixel replication; every output
// is registered one cycle after the h/v counter state.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = int'(SVGA_800x600_60.h_active),
   parameter int H_FP     = int'(SVGA_800x600_60.h_fp),
   parameter int H_SYNC   = int'(SVGA_800x600_60.h_sync),
   parameter int H_BP     = int'(SVGA_800x600_60.h_bp),
   parameter int V_ACTIVE = int'(SVGA_800x600_60.v_active),
   parameter int V_FP     = int'(SVGA_800x600_60.v_fp),
   parameter int V_SYNC   = int'(SVGA_800x600_60.v_sync),
   parameter int V_BP     = int'(SVGA_800x600_60.v_bp),
   parameter int H_POL    = int'(SVGA_800x600_60.h_pol),
   parameter int V_POL    = int'(SVGA_800x600_60.v_pol)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [1:0]       scale,
   output logic             o_hsync,
   output logic             o_vsync,
   output logic             o_blank,
   output logic             o_sync,
   output logic             o_clock,
   output logic [CNT_W-1:0] o_x,
   output logic [CNT_W-1:0] o_y,
   output logic             o_active,
   output logic             o_line_start,
   output logic             o_frame_start,
   output logic             o_vblank
);

   localparam logic L_HP = (H_POL != 0);
   localparam logic L_VP = (V_POL != 0);

   vga_axis_if w_h ();
   vga_axis_if w_v ();

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .POL    (H_POL)
   ) u_h_axis (
      .clock  (clock),
      .reset  (reset),
      .i_tick (1'b1),
      .o_axis (w_h)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .POL    (V_POL)
   ) u_v_axis (
      .clock  (clock),
      .reset  (reset),
      .i_tick (w_h.wrap),
      .o_axis (w_v)
   );

   logic [1:0]       r_shift;
   logic             w_vis;
   logic             w_h0;
   logic [CNT_W-1:0] w_x;
   logic [CNT_W-1:0] w_y;

   // Vertical wrap only fires on the last pixel of the frame.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_shift <= '0;
      end else if (w_v.wrap) begin
         r_shift <= scale_shift(scale);
      end
   end

   assign w_vis = w_h.in_active & w_v.in_active;
   assign w_h0  = (w_h.count == '0);
   assign w_x   = w_vis ? (w_h.count >> r_shift) : '0;
   assign w_y   = w_vis ? (w_v.count >> r_shift) : '0;

   always_ff @(posedge clock) begin
      if (reset) begin
         o_hsync       <= ~L_HP;
         o_vsync       <= ~L_VP;
         o_blank       <= 1'b0;
         o_active      <= 1'b0;
         o_x           <= '0;
         o_y           <= '0;
         o_line_start  <= 1'b0;
         o_frame_start <= 1'b0;
         o_vblank      <= 1'b0;
      end else begin
         o_hsync       <= w_h.in_sync ? L_HP : ~L_HP;
         o_vsync       <= w_v.in_sync ? L_VP : ~L_VP;
         o_blank       <= w_vis;
         o_active      <= w_vis;
         o_x           <= w_x;
         o_y           <= w_y;
         o_line_start  <= w_h0 & w_v.in_active;
         o_frame_start <= w_h0 & (w_v.count == '0);
         o_vblank      <= ~w_v.in_active;
      end
   end

   assign o_sync  = 1'b1;
   assign o_clock = clock;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small raster configurations
// compared every cycle against a position-from-cycle-count model.
module tb_vga_timing_gen;

   localparam int MHA = 16, MHF = 2, MHS = 3, MHB = 3;
   localparam int MVA = 8,  MVF = 1, MVS = 2, MVB = 2;
   localparam int MHP = 1,  MVP = 0;
   localparam int M_FRAME = (MHA + MHF + MHS + MHB) * (MVA + MVF + MVS + MVB);

   localparam int SHA = 4, SHF = 1, SHS = 2, SHB = 1;
   localparam int SVA = 3, SVF = 1, SVS = 1, SVB = 1;
   localparam int SHP = 0, SVP = 1;
   localparam int S_FRAME = (SHA + SHF + SHS + SHB) * (SVA + SVF + SVS + SVB);

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        bl;
      logic        act;
      logic [10:0] x;
      logic [10:0] y;
      logic        ls;
      logic        fs;
      logic        vb;
      logic        sy;
   } obs_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] scale_m = 2'd0;
   logic [1:0] scale_s = 2'd0;

   int n_tests = 0;
   int n_fail  = 0;
   int edges   = 0;
   int sh_m    = 0;
   int sh_s    = 0;
   int blank_s = 0;
   int hslo_s  = 0;
   int fs_s    = 0;

   always #5 clock = ~clock;

   vga_timing_gen_if if_m ();
   vga_timing_gen_if if_s ();

   vga_timing_gen #(
      .H_ACTIVE (MHA), .H_FP (MHF), .H_SYNC (MHS), .H_BP (MHB),
      .V_ACTIVE (MVA), .V_FP (MVF), .V_SYNC (MVS), .V_BP (MVB),
      .H_POL    (MHP), .V_POL (MVP)
   ) u_dut_m (
      .clock         (clock),
      .reset         (reset),
      .scale         (scale_m),
      .o_hsync       (if_m.hsync),
      .o_vsync       (if_m.vsync),
      .o_blank       (if_m.blank),
      .o_sync        (if_m.sync),
      .o_clock       (if_m.pclk),
      .o_x           (if_m.x),
      .o_y           (if_m.y),
      .o_active      (if_m.active),
      .o_line_start  (if_m.line_start),
      .o_frame_start (if_m.frame_start),
      .o_vblank      (if_m.vblank)
   );

   vga_timing_gen #(
      .H_ACTIVE (SHA), .H_FP (SHF), .H_SYNC (SHS), .H_BP (SHB),
      .V_ACTIVE (SVA), .V_FP (SVF), .V_SYNC (SVS), .V_BP (SVB),
      .H_POL    (SHP), .V_POL (SVP)
   ) u_dut_s (
      .clock         (clock),
      .reset         (reset),
      .scale         (scale_s),
      .o_hsync       (if_s.hsync),
      .o_vsync       (if_s.vsync),
      .o_blank       (if_s.blank),
      .o_sync        (if_s.sync),
      .o_clock       (if_s.pclk),
      .o_x           (if_s.x),
      .o_y           (if_s.y),
      .o_active      (if_s.active),
      .o_line_start  (if_s.line_start),
      .o_frame_start (if_s.frame_start),
      .o_vblank      (if_s.vblank)
   );

   obs_t got_m;
   obs_t got_s;

   assign got_m = {if_m.hsync, if_m.vsync, if_m.blank, if_m.active,
                   if_m.x, if_m.y, if_m.line_start, if_m.frame_start,
                   if_m.vblank, if_m.sync};
   assign got_s = {if_s.hsync, if_s.vsync, if_s.blank, if_s.active,
                   if_s.x, if_s.y, if_s.line_start, if_s.frame_start,
                   if_s.vblank, if_s.sync};

   // Expected outputs for raster position pos within a frame.
   function automatic obs_t model(input int ha, hf, hs, hb,
                                  input int va, vf, vs, vb,
                                  input int hp, vp, pos, sh);
      obs_t o;
      int   ht;
      int   h;
      int   v;
      bit   vis;
      ht    = ha + hf + hs + hb;
      h     = pos % ht;
      v     = pos / ht;
      vis   = (h < ha) && (v < va);
      o.hs  = ((h >= ha + hf) && (h < ha + hf + hs)) == (hp != 0);
      o.vs  = ((v >= va + vf) && (v < va + vf + vs)) == (vp != 0);
      o.bl  = vis;
      o.act = vis;
      o.x   = vis ? 11'(h >> sh) : 11'd0;
      o.y   = vis ? 11'(v >> sh) : 11'd0;
      o.ls  = (h == 0) && (v < va);
      o.fs  = (h == 0) && (v == 0);
      o.vb  = (v >= va);
      o.sy  = 1'b1;
      return o;
   endfunction

   function automatic obs_t rst_model(input int hp, vp);
      obs_t o;
      o    = '0;
      o.hs = (hp == 0);
      o.vs = (vp == 0);
      o.sy = 1'b1;
      return o;
   endfunction

   function automatic int shift_of(input logic [1:0] s);
      return (s == 2'd0) ? 0 : (s == 2'd1) ? 1 : 2;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h edge=%0d",
                tag, obs, exp, edges);
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         if (reset) edges = 0;
         else       edges++;
         @(negedge clock);
         if (edges == 0) begin
            chk("rst_m", got_m, rst_model(MHP, MVP));
            chk("rst_s", got_s, rst_model(SHP, SVP));
            sh_m = 0;
            sh_s = 0;
         end else begin
            chk("pix_m", got_m, model(MHA, MHF, MHS, MHB, MVA, MVF, MVS, MVB,
                                      MHP, MVP, (edges - 1) % M_FRAME, sh_m));
            chk("pix_s", got_s, model(SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB,
                                      SHP, SVP, (edges - 1) % S_FRAME, sh_s));
            if (edges % M_FRAME == 0) sh_m = shift_of(scale_m);
            if (edges % S_FRAME == 0) sh_s = shift_of(scale_s);
            blank_s += int'(if_s.blank);
            hslo_s  += int'(!if_s.hsync);
            fs_s    += int'(if_s.frame_start);
         end
      end
   endtask

   initial begin
      int c;
      reset   = 1'b1;
      scale_m = 2'd0;
      scale_s = 2'd0;
      run(3);
      chk("oclk_lo", if_m.pclk, 32'd0);

      reset = 1'b0;
      run(1);
      chk("first_fs_m", {if_m.frame_start, if_m.blank}, 32'd3);
      chk("first_fs_s", {if_s.frame_start, if_s.line_start}, 32'd3);

      // Scale 1 applies from the second frame onward.
      scale_m = 2'd1;
      scale_s = 2'd1;
      run(2 * M_FRAME);

      // Mid-frame change must wait for the next frame boundary.
      run(57);
      scale_m = 2'd2;
      scale_s = 2'd3;
      run(M_FRAME);

      blank_s = 0;
      hslo_s  = 0;
      fs_s    = 0;
      run(S_FRAME);
      chk("blank_cnt_s", blank_s, SHA * SVA);
      chk("hslo_cnt_s", hslo_s, SHS * (SVA + SVF + SVS + SVB));
      chk("fs_cnt_s", fs_s, 1);

      c = 0;
      do begin run(1); c++; end
      while (!if_m.frame_start && c < 2 * M_FRAME);
      c = 0;
      do begin run(1); c++; end
      while (!if_m.frame_start && c < 2 * M_FRAME);
      chk("fs_period_m", c, M_FRAME);

      for (int k = 0; k < 16; k++) begin
         scale_m = 2'($urandom_range(0, 3));
         scale_s = 2'($urandom_range(0, 3));
         run(int'($urandom_range(1, 200)));
      end

      // Reset in the middle of a horizontal sync pulse.
      c = 0;
      do begin run(1); c++; end
      while (if_m.hsync !== 1'(MHP) && c < M_FRAME);
      chk("find_hsync_m", if_m.hsync, 32'(MHP));
      reset = 1'b1;
      run(3);
      reset = 1'b0;
      run(1);
      chk("rst_mid_fs", if_m.frame_start, 32'd1);
      chk("rst_mid_xy", {if_m.x, if_m.y}, 32'd0);
      chk("rst_mid_hs", if_m.hsync, 32'(MHP == 0));

      for (int k = 0; k < 8; k++) begin
         scale_m = 2'($urandom_range(0, 3));
         scale_s = 2'($urandom_range(0, 3));
         run(int'($urandom_range(50, 400)));
      end

      @(posedge clock);
      #1;
      chk("oclk_hi", if_s.pclk, 32'd1);
      @(negedge clock);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
